fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Sits directly downstream of draw_line and consumes its pixel stream (wr_valid, write_x_pos, write_y_pos).
- Clips each pixel to the framebuffer bounds and converts (x,y) to a linear display-SRAM address.
- Buffers pixels in a small FIFO and drives the display-SRAM write port, which may stall (scanout has priority).
- Also provides a clear-screen fill sequence.

Parameters:
- FB_WIDTH, 160, framebuffer columns.
- FB_HEIGHT, 120, framebuffer rows.
- COLOR_W, 1, bits per pixel.
- FIFO_DEPTH, 8, pixel FIFO entries; power of 2, at least 2.
- ADDR_W, 15, SRAM address width; must hold FB_WIDTH*FB_HEIGHT-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel write strobe (draw_line wr_valid).
- pix_x  in  8  pixel column (draw_line write_x_pos).
- pix_y  in  7  pixel row (draw_line write_y_pos).
- pix_color  in  COLOR_W  pixel colour.
- clear_start  in  1  one-cycle pulse requesting a full-screen fill.
- clear_color  in  COLOR_W  fill colour; sampled on the clear_start cycle.
- sram_we  out  1  write request to the SRAM controller.
- sram_addr  out  ADDR_W  linear address, y*FB_WIDTH+x.
- sram_wdata  out  COLOR_W  write data.
- sram_ready  in  1  controller accepts the write this cycle.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- busy  out  1  high when the FIFO is non-empty, a clear is pending, or a clear is in progress.

Behaviour:
- Reset: FIFO empty, state DRAW, clear pending cleared. All outputs 0: sram_we, sram_addr, sram_wdata, fifo_full, overflow, busy. A reset during CLEAR aborts the fill immediately.
- Handshake: a write completes on any cycle where sram_we && sram_ready. While sram_we=1 and the write has not completed, sram_addr and sram_wdata are held stable.
- Clipping: a pixel with pix_x>=FB_WIDTH or pix_y>=FB_HEIGHT is discarded. It is not counted as overflow.
- Address arithmetic: computed at enqueue as pix_y*FB_WIDTH+pix_x, unsigned, ADDR_W bits. The address and pix_color are stored in the FIFO.
- Push condition: pix_valid && in range && (!fifo_full || pop this cycle). Simultaneous push and pop while full is allowed.
- Full drop: pix_valid, in range, full, and no pop in that cycle → pixel dropped and overflow set. overflow clears only on rst or an accepted clear_start.
- Latency: a pixel accepted at edge N appears on sram_we/sram_addr at cycle N+1 if the FIFO was empty. FIFO order is preserved.
- State DRAW:
  - sram_we = FIFO non-empty; outputs present the FIFO head.
  - Pop on write completion.
  - clear_start sets the pending flag and latches clear_color.
  - Go to CLEAR once pending is set and the FIFO is empty, so queued pixels drain first.
  - If clear_start arrives with the FIFO already empty, CLEAR is entered on the next edge.
- State CLEAR:
  - sram_we=1, sram_wdata = latched colour.
  - sram_addr counts from 0 to FB_WIDTH*FB_HEIGHT-1, advancing only on write completion.
  - After the last address completes, clear pending and return to DRAW.
  - Pixels arriving during CLEAR are still enqueued (or dropped if full) and written after the fill.
  - clear_start during CLEAR or while already pending is ignored.
- Output timing: fifo_full and busy are registered and reflect state after each edge.
- Idle outputs: when sram_we=0, sram_addr and sram_wdata are driven 0.

Optional Feature:
- Macro: FB_PIXEL_WRITER_CLIP_COUNT_EN.
- Defined:
  - Adds output clip_count, 16 bits, out, initialised to 0.
  - Increments on every pix_valid cycle whose pixel is clipped.
  - Saturates at 0xFFFF; reset to 0 by rst.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- sram_ready=1; single pixel (x=12, y=15, colour 1) → next cycle sram_we=1, sram_addr=2412, sram_wdata=1, then sram_we=0.
- pix_valid with x=160,y=5, then x=3,y=120, then x=159,y=119 → only one write, addr 19199. overflow stays 0; clip_count=2 when the feature is enabled.
- sram_ready=0; 10 consecutive in-range pixels → fifo_full=1 after the 8th push and overflow=1 on the 9th. Releasing ready yields exactly 8 writes in input order.
- Queue 3 pixels with sram_ready=0, pulse clear_start with clear_color=1, then raise ready → the 3 pixel writes complete first, then 19200 writes with addresses 0..19199 and wdata=1. busy falls the cycle after the last one.
- Mid-CLEAR, toggle sram_ready 1/0 every cycle and assert rst at address 5000 → address advances only on ready. After rst all outputs are 0, the state is DRAW, and a following pixel (0,0) writes addr 0.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// Clips draw_line pixels to the framebuffer, queues them with linear SRAM addresses, and runs a clear-screen fill.
// Optional saturating clip counter output: define FB_PIXEL_WRITER_CLIP_COUNT_EN.
module fb_pixel_writer #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int COLOR_W    = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [7:0]         pix_x,
  input  logic [6:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               sram_we,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [COLOR_W-1:0] sram_wdata,
  input  logic               sram_ready,
  output logic               fifo_full,
  output logic               overflow,
`ifdef FB_PIXEL_WRITER_CLIP_COUNT_EN
  output logic [15:0]        clip_count,
`endif
  output logic               busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic {DRAW, CLEAR} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } entry_t;

  state_t             state;
  logic               pending;
  logic [ADDR_W-1:0]  clr_addr;
  logic [COLOR_W-1:0] clr_color;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  entry_t             head;

  logic in_range;
  logic pop;
  logic push;
  logic drop;
  logic clr_accept;
  logic clear_done;
  logic busy_next;
  entry_t new_entry;

  assign in_range  = (int'(pix_x) < FB_WIDTH) && (int'(pix_y) < FB_HEIGHT);
  assign head      = mem[rd_ptr];
  // Pops happen only in DRAW; during a fill the queued pixels wait for the fill to finish.
  assign pop       = (state == DRAW) && (count != '0) && sram_ready;
  assign push      = pix_valid && in_range && (!fifo_full || pop);
  assign drop      = pix_valid && in_range && fifo_full && !pop;
  assign clr_accept = clear_start && (state == DRAW) && !pending;
  assign clear_done = (state == CLEAR) && sram_ready && (clr_addr == LAST_ADDR);

  assign new_entry.addr  = ADDR_W'(pix_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(pix_x);
  assign new_entry.color = pix_color;

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign busy_next  = (count_next != '0) || ((pending || clr_accept) && !clear_done);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state == CLEAR) begin
      sram_we    = 1'b1;
      sram_addr  = clr_addr;
      sram_wdata = clr_color;
    end else if (count != '0) begin
      sram_we    = 1'b1;
      sram_addr  = head.addr;
      sram_wdata = head.color;
    end
  end

  // NOTE: the FIFO storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRAW;
      pending   <= 1'b0;
      clr_addr  <= '0;
      clr_color <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      count     <= count_next;
      fifo_full <= (count_next == CNT_W'(FIFO_DEPTH));
      busy      <= busy_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (drop)            overflow <= 1'b1;
      else if (clr_accept) overflow <= 1'b0;

      if (clr_accept) begin
        pending   <= 1'b1;
        clr_color <= clear_color;
      end

      case (state)
        DRAW: begin
          // Queued pixels drain before the fill starts.
          if (pending && count == '0) state <= CLEAR;
        end
        CLEAR: begin
          if (sram_ready) begin
            if (clr_addr == LAST_ADDR) begin
              state    <= DRAW;
              pending  <= 1'b0;
              clr_addr <= '0;
            end else begin
              clr_addr <= clr_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= DRAW;
      endcase
    end
  end

`ifdef FB_PIXEL_WRITER_CLIP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count <= '0;
    end else if (pix_valid && !in_range && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: single write, clipping, overflow, clear-screen ordering and reset mid-fill.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [0:0]  pix_color;
  logic        clear_start;
  logic [0:0]  clear_color;
  logic        sram_we;
  logic [14:0] sram_addr;
  logic [0:0]  sram_wdata;
  logic        sram_ready;
  logic        fifo_full;
  logic        overflow;
  logic        busy;
`ifdef FB_PIXEL_WRITER_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int addr_log[$];
  int data_log[$];

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_ready  (sram_ready),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
`ifdef FB_PIXEL_WRITER_CLIP_COUNT_EN
    .clip_count  (clip_count),
`endif
    .busy        (busy)
  );

  // Completed writes, in order.
  always @(posedge clk) begin
    if (!rst && sram_we && sram_ready) begin
      addr_log.push_back(int'(sram_addr));
      data_log.push_back(int'(sram_wdata));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic v, input int x, input int y, input logic c);
    pix_valid = v;
    pix_x     = 8'(x);
    pix_y     = 7'(y);
    pix_color = c;
  endtask

  initial begin
    int errs;
    int prev_size;
    int cycles;
    logic [14:0] exp_addr;

    rst = 1'b1;
    set_pix(1'b0, 0, 0, 1'b0);
    clear_start = 1'b0;
    clear_color = 1'b0;
    sram_ready  = 1'b1;
    tick();
    tick();
    check("rst_we", sram_we, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single pixel.
    set_pix(1'b1, 12, 15, 1'b1);
    tick();
    set_pix(1'b0, 0, 0, 1'b0);
    check("single_we", sram_we, 1);
    check("single_addr", sram_addr, 2412);
    check("single_wdata", sram_wdata, 1);
    tick();
    check("single_we_off", sram_we, 0);

    // Clipping.
    addr_log.delete();
    data_log.delete();
    set_pix(1'b1, 160, 5, 1'b1);
    tick();
    set_pix(1'b1, 3, 120, 1'b1);
    tick();
    set_pix(1'b1, 159, 119, 1'b0);
    tick();
    set_pix(1'b0, 0, 0, 1'b0);
    check("clip_addr", sram_addr, 19199);
    tick();
    tick();
    check("clip_writes", addr_log.size(), 1);
    check("clip_ovf", overflow, 0);
`ifdef FB_PIXEL_WRITER_CLIP_COUNT_EN
    check("clip_count", clip_count, 2);
`endif

    // Overflow with a stalled SRAM.
    addr_log.delete();
    data_log.delete();
    sram_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_pix(1'b1, i, 1, i[0]);
      tick();
      if (i == 6) check("full_after7", fifo_full, 0);
      if (i == 7) begin
        check("full_after8", fifo_full, 1);
        check("ovf_after8", overflow, 0);
      end
      if (i == 8) check("ovf_after9", overflow, 1);
    end
    set_pix(1'b0, 0, 0, 1'b0);
    check("stall_hold_addr", sram_addr, 160);
    sram_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("ovf_writes", addr_log.size(), 8);
    errs = 0;
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      if (addr_log[i] != 160 + i || data_log[i] != (i & 1)) errs++;
    end
    check("ovf_order_errs", errs, 0);
    check("ovf_drain_busy", busy, 0);
    check("ovf_sticky", overflow, 1);

    // Clear after three queued pixels.
    addr_log.delete();
    data_log.delete();
    sram_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_pix(1'b1, i, 0, 1'b0);
      tick();
    end
    set_pix(1'b0, 0, 0, 1'b0);
    clear_start = 1'b1;
    clear_color = 1'b1;
    tick();
    clear_start = 1'b0;
    clear_color = 1'b0;
    check("clr_busy", busy, 1);
    check("clr_ovf_cleared", overflow, 0);
    sram_ready = 1'b1;
    prev_size = addr_log.size();
    cycles = 0;
    while (busy && cycles < 25000) begin
      prev_size = addr_log.size();
      tick();
      cycles++;
    end
    check("clr_timeout", (cycles < 25000) ? 1 : 0, 1);
    check("clr_total_writes", addr_log.size(), 19203);
    check("clr_prev_size", prev_size, 19202);
    errs = 0;
    for (int i = 0; i < addr_log.size(); i++) begin
      if (i < 3) begin
        if (addr_log[i] != i + 1 || data_log[i] != 0) errs++;
      end else if (addr_log[i] != i - 3 || data_log[i] != 1) begin
        errs++;
      end
    end
    check("clr_seq_errs", errs, 0);
    check("clr_we_off", sram_we, 0);

    // Reset mid-fill with a toggling ready.
    clear_start = 1'b1;
    clear_color = 1'b1;
    tick();
    clear_start = 1'b0;
    tick();
    check("fill2_addr0", sram_addr, 0);
    check("fill2_we", sram_we, 1);
    errs = 0;
    cycles = 0;
    while (sram_addr != 15'd5000 && cycles < 20000) begin
      sram_ready = ~sram_ready;
      exp_addr = sram_addr + 15'(sram_ready);
      tick();
      cycles++;
      if (sram_addr != exp_addr) errs++;
    end
    check("fill2_reach5000", sram_addr, 5000);
    check("fill2_step_errs", errs, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_we", sram_we, 0);
    check("rst2_addr", sram_addr, 0);
    check("rst2_wdata", sram_wdata, 0);
    check("rst2_busy", busy, 0);
    check("rst2_full", fifo_full, 0);
    check("rst2_ovf", overflow, 0);
    sram_ready = 1'b1;
    set_pix(1'b1, 0, 0, 1'b1);
    tick();
    set_pix(1'b0, 0, 0, 1'b0);
    check("post_we", sram_we, 1);
    check("post_addr", sram_addr, 0);
    check("post_wdata", sram_wdata, 1);
    tick();
    check("post_we_off", sram_we, 0);
    check("post_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
